vram_arbiter: RTL and testbench

Single-port video RAM arbiter that shares one synchronous 16 KB screen RAM between the ULA video fetch path and the Z80 CPU bus. It sits between `hdmi_video`'s `vram_address`/`vram_data` pair, the CPU memory decoder (0x4000–0x7FFF window) and the RAM macro. Video fetches have strict priority and fixed latency; CPU accesses are queued and acknowledged.

---
 rtl/zx_vram_pkg.sv | 23 ++
 rtl/vram_arb_pipe.sv | 55 +++++
 rtl/vram_arbiter_chk.sv | 16 +
 rtl/vram_arbiter.sv | 117 +++++++++++
 tb/tb_vram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zx_vram_pkg.sv
// Shared types and default widths for the ZX screen-RAM arbiter.
package zx_vram_pkg;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_ISSUED = 2'd1,
    C_DONE   = 2'd2
  } cpu_state_t;

  localparam int RAM_AW_DEF = 14;
  localparam int VID_AW_DEF = 13;

  typedef enum {SRC_NONE, SRC_VID, SRC_CPU} src_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/vram_arb_pipe.sv
// Two-stage owner tag pipeline that steers RAM read data back to video or CPU.
module vram_arb_pipe
  import zx_vram_pkg::*;
(
  input  logic       clk_pix,
  input  logic       nreset,
  input  src_t       grant_src,
  input  logic       grant_we,
  input  logic [7:0] ram_rdata,
  output logic [7:0] vid_data,
  output logic       vid_valid,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack
);

  src_t grant_src_r;
  src_t tag_src_r;
  logic grant_we_r;
  logic tag_we_r;

  // Carry each grant's owner alongside its RAM access until the data returns.
  always_ff @(posedge clk_pix) begin
    if (!nreset) begin
      grant_src_r <= SRC_NONE;
      grant_we_r  <= 1'b0;
      tag_src_r   <= SRC_NONE;
      tag_we_r    <= 1'b0;
    end else begin
      grant_src_r <= grant_src;
      grant_we_r  <= grant_we;
      tag_src_r   <= grant_src_r;
      tag_we_r    <= grant_we_r;
    end
  end

  // Result stage; a CPU write completes with an ack but leaves cpu_rdata alone.
  always_ff @(posedge clk_pix) begin
    if (!nreset) begin
      vid_data  <= 8'd0;
      vid_valid <= 1'b0;
      cpu_rdata <= 8'd0;
      cpu_ack   <= 1'b0;
    end else begin
      vid_valid <= (tag_src_r == SRC_VID);
      cpu_ack   <= (tag_src_r == SRC_CPU);
      if (tag_src_r == SRC_VID) begin
        vid_data <= ram_rdata;
      end
      if ((tag_src_r == SRC_CPU) && !tag_we_r) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter_chk.sv
// Protocol checks for the screen-RAM arbiter environment.
module vram_arbiter_chk (
  input logic clk_pix,
  input logic nreset,
  input logic vid_req,
  input logic cpu_ack
);

  // Three video strobes in a row means the video side is flooding the port.
  a_no_vid_flood: assert property (@(posedge clk_pix) disable iff (!nreset)
    !(vid_req && $past(vid_req) && $past(vid_req, 2)));

  a_ack_pulse: assert property (@(posedge clk_pix) disable iff (!nreset)
    cpu_ack |=> !cpu_ack);

endmodule

// File: rtl/vram_arbiter.sv
// Video/CPU arbiter for the single-port screen RAM; video fetches always win.
// Optional CPU wait-cycle counter output: define VRAM_ARB_WAITCNT_EN.
module vram_arbiter
  import zx_vram_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF,
  parameter int VID_AW = VID_AW_DEF
) (
  input  logic              clk_pix,
  input  logic              nreset,
  input  logic              vid_req,
  input  logic [VID_AW-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_nwait,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
`ifdef VRAM_ARB_WAITCNT_EN
  ,
  output logic [15:0]       cpu_wait_cycles
`endif
);

  cpu_state_t state_r;
  src_t       grant_src_s;
  logic       grant_we_s;

  // Grant decision for this edge.
  always_comb begin
    grant_src_s = SRC_NONE;
    grant_we_s  = 1'b0;
    if (vid_req) begin
      grant_src_s = SRC_VID;
    end else if (cpu_req && (state_r == C_IDLE)) begin
      grant_src_s = SRC_CPU;
      grant_we_s  = cpu_we;
    end else begin
      grant_src_s = SRC_NONE;
    end
  end

  // RAM port registers, CPU access FSM and the Z80 WAIT line.
  always_ff @(posedge clk_pix) begin
    if (!nreset) begin
      state_r   <= C_IDLE;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= 8'd0;
      cpu_nwait <= 1'b1;
    end else begin
      case (grant_src_s)
        SRC_VID: begin
          ram_addr <= {1'b0, vid_addr};
          ram_we   <= 1'b0;
        end
        SRC_CPU: begin
          ram_addr  <= cpu_addr;
          ram_we    <= cpu_we;
          ram_wdata <= cpu_wdata;
        end
        default: ram_we <= 1'b0;
      endcase

      case (state_r)
        C_IDLE:   state_r <= (grant_src_s == SRC_CPU) ? C_ISSUED : C_IDLE;
        C_ISSUED: state_r <= C_DONE;
        C_DONE:   state_r <= C_IDLE;
        default:  state_r <= C_IDLE;
      endcase

      // The ack edge is the one leaving C_DONE, so WAIT releases together with it.
      cpu_nwait <= !(cpu_req && (state_r != C_DONE));
    end
  end

  vram_arb_pipe u_pipe (
    .clk_pix   (clk_pix),
    .nreset    (nreset),
    .grant_src (grant_src_s),
    .grant_we  (grant_we_s),
    .ram_rdata (ram_rdata),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack)
  );

`ifdef VRAM_ARB_WAITCNT_EN
  logic vid_req_d_r;

  // Count WAIT-asserted clocks since the last frame-start fetch.
  always_ff @(posedge clk_pix) begin
    if (!nreset) begin
      vid_req_d_r     <= 1'b0;
      cpu_wait_cycles <= 16'd0;
    end else begin
      vid_req_d_r <= vid_req;
      if (vid_req && !vid_req_d_r && (vid_addr == '0)) begin
        cpu_wait_cycles <= 16'd0;
      end else if (!cpu_nwait) begin
        cpu_wait_cycles <= sat_inc16(cpu_wait_cycles);
      end else begin
        cpu_wait_cycles <= cpu_wait_cycles;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter driving a behavioural one-cycle-latency RAM.
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int RAM_AW = 14;
  localparam int VID_AW = 13;

  logic              clk_pix   = 1'b0;
  logic              nreset    = 1'b0;
  logic              vid_req   = 1'b0;
  logic [VID_AW-1:0] vid_addr  = '0;
  logic [7:0]        vid_data;
  logic              vid_valid;
  logic              cpu_req   = 1'b0;
  logic              cpu_we    = 1'b0;
  logic [RAM_AW-1:0] cpu_addr  = '0;
  logic [7:0]        cpu_wdata = 8'h00;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              cpu_nwait;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata = 8'h00;
`ifdef VRAM_ARB_WAITCNT_EN
  logic [15:0]       cpu_wait_cycles;
`endif

  logic [7:0] mem     [0:16383];
  logic [7:0] ref_mem [0:16383];

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t       vid_q[$];
  exp_t       cpu_q[$];
  int         cyc    = 0;
  int         n_cmp  = 0;
  int         n_err  = 0;
  logic [7:0] rd_hold = 8'h00;

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) cyc <= cyc + 1;

  always @(posedge clk_pix) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  vram_arbiter #(.RAM_AW(RAM_AW), .VID_AW(VID_AW)) dut (
    .clk_pix   (clk_pix),
    .nreset    (nreset),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_nwait (cpu_nwait),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef VRAM_ARB_WAITCNT_EN
    ,
    .cpu_wait_cycles (cpu_wait_cycles)
`endif
  );

  vram_arbiter_chk u_chk (
    .clk_pix (clk_pix),
    .nreset  (nreset),
    .vid_req (vid_req),
    .cpu_ack (cpu_ack)
  );

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  function automatic logic vid_slot(input int k);
    return (k >= 0) && (k < 64) && ((k % 16 == 10) || (k % 16 == 12));
  endfunction

  // Scoreboard: pop on each result strobe, or flag an expected strobe that never came.
  always @(negedge clk_pix) begin
    exp_t e;
    if (vid_valid) begin
      n_cmp++;
      if (vid_q.size() == 0) begin
        n_err++;
        $display("FAIL vid_unexpected at cyc=%0d: got data=%02h, required no strobe", cyc, vid_data);
      end else begin
        e = vid_q.pop_front();
        if (e.cyc !== cyc || e.data !== vid_data) begin
          n_err++;
          $display("FAIL vid_result: got cyc=%0d data=%02h, required cyc=%0d data=%02h", cyc, vid_data, e.cyc, e.data);
        end
      end
    end else if (vid_q.size() != 0 && vid_q[0].cyc <= cyc) begin
      n_cmp++;
      n_err++;
      e = vid_q.pop_front();
      $display("FAIL vid_missing: got no strobe by cyc=%0d, required data=%02h at cyc=%0d", cyc, e.data, e.cyc);
    end

    if (cpu_ack) begin
      n_cmp++;
      if (cpu_q.size() == 0) begin
        n_err++;
        $display("FAIL cpu_unexpected at cyc=%0d: got ack rdata=%02h, required no ack", cyc, cpu_rdata);
      end else begin
        e = cpu_q.pop_front();
        if (e.cyc !== cyc || e.data !== cpu_rdata) begin
          n_err++;
          $display("FAIL cpu_result: got cyc=%0d rdata=%02h, required cyc=%0d rdata=%02h", cyc, cpu_rdata, e.cyc, e.data);
        end
      end
    end else if (cpu_q.size() != 0 && cpu_q[0].cyc <= cyc) begin
      n_cmp++;
      n_err++;
      e = cpu_q.pop_front();
      $display("FAIL cpu_missing: got no ack by cyc=%0d, required rdata=%02h at cyc=%0d", cyc, e.data, e.cyc);
    end
  end

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk_pix);
    n_cmp++;
    if ({vid_valid, cpu_ack, cpu_nwait, ram_we} !== 4'b0010) begin
      n_err++;
      $display("FAIL reset_ctrl: got {vv,ack,nwait,we}=%b, required 0010", {vid_valid, cpu_ack, cpu_nwait, ram_we});
    end
    n_cmp++;
    if (ram_addr !== 14'd0) begin
      n_err++;
      $display("FAIL reset_ram_addr: got %h, required 0000", ram_addr);
    end
    n_cmp++;
    if (ram_wdata !== 8'd0) begin
      n_err++;
      $display("FAIL reset_ram_wdata: got %h, required 00", ram_wdata);
    end
    n_cmp++;
    if ({vid_data, cpu_rdata} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_data: got vid_data=%h cpu_rdata=%h, required 00/00", vid_data, cpu_rdata);
    end
    nreset = 1'b1;
  endtask

  task automatic test_video_read();
    @(negedge clk_pix);
    mem[14'h0123] <= 8'hA5;
    ref_mem[14'h0123] = 8'hA5;
    vid_req  = 1'b1;
    vid_addr = 13'h0123;
    vid_q.push_back(exp_t'{cyc + 3, 8'hA5});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_pix);
      vid_req = 1'b0;
      n_cmp++;
      if (vid_valid !== (j == 2)) begin
        n_err++;
        $display("FAIL vid_latency slot %0d: got vid_valid=%b, required %b", j, vid_valid, (j == 2));
      end
    end
  endtask

  task automatic test_cpu_rw();
    for (int a = 0; a < 2; a++) begin
      @(negedge clk_pix);
      cpu_req   = 1'b1;
      cpu_we    = (a == 0);
      cpu_addr  = 14'h1800;
      cpu_wdata = 8'h3C;
      if (a == 0) ref_mem[14'h1800] = 8'h3C;
      else        rd_hold = ref_mem[14'h1800];
      cpu_q.push_back(exp_t'{cyc + 3, rd_hold});
      for (int j = 0; j < 3; j++) begin
        @(negedge clk_pix);
        n_cmp++;
        if (cpu_nwait !== (j == 2)) begin
          n_err++;
          $display("FAIL cpu_rw_nwait access %0d slot %0d: got %b, required %b", a, j, cpu_nwait, (j == 2));
        end
      end
      cpu_req = 1'b0;
    end
  endtask

  task automatic test_collision();
    @(negedge clk_pix);
    vid_req  = 1'b1;
    vid_addr = 13'h0040;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'h1801;
    vid_q.push_back(exp_t'{cyc + 3, ref_mem[14'h0040]});
    rd_hold = ref_mem[14'h1801];
    cpu_q.push_back(exp_t'{cyc + 4, rd_hold});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_pix);
      vid_req = 1'b0;
      n_cmp++;
      if (cpu_nwait !== (j == 3)) begin
        n_err++;
        $display("FAIL collision_nwait slot %0d: got %b, required %b", j, cpu_nwait, (j == 3));
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_video_cpu_pressure();
    int e0;
    int seen;
    int g;
    int acks_seen;
    @(negedge clk_pix);
    e0   = cyc + 1;
    seen = e0;
    // Each CPU access is served at the first non-video edge after it is seen.
    for (int n = 0; n < 16; n++) begin
      g = seen;
      while (vid_slot(g - e0)) g++;
      rd_hold = ref_mem[14'h1800 + 14'(n)];
      cpu_q.push_back(exp_t'{g + 2, rd_hold});
      seen = g + 3;
    end
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 14'h1800;
    acks_seen = 0;
    for (int k = 0; k < 80; k++) begin
      vid_req  = vid_slot(k);
      vid_addr = 13'(k * 7 + 3);
      if (vid_slot(k)) vid_q.push_back(exp_t'{e0 + k + 2, ref_mem[14'(k * 7 + 3)]});
      @(negedge clk_pix);
      if (cpu_ack) acks_seen++;
      cpu_req  = (acks_seen < 16);
      cpu_addr = 14'h1800 + 14'(acks_seen);
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk_pix);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 14'h0200;
    cpu_wdata = 8'h77;
    // The RAM samples the registered write on the reset edge, so it lands.
    ref_mem[14'h0200] = 8'h77;
    @(negedge clk_pix);
    nreset  = 1'b0;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    @(negedge clk_pix);
    n_cmp++;
    if ({cpu_ack, cpu_nwait, ram_we} !== 3'b010) begin
      n_err++;
      $display("FAIL midreset_ctrl: got {ack,nwait,we}=%b, required 010", {cpu_ack, cpu_nwait, ram_we});
    end
    n_cmp++;
    if (ram_addr !== 14'd0 || cpu_rdata !== 8'd0) begin
      n_err++;
      $display("FAIL midreset_regs: got ram_addr=%h cpu_rdata=%h, required 0000/00", ram_addr, cpu_rdata);
    end
    nreset  = 1'b1;
    rd_hold = 8'h00;
    repeat (4) @(negedge clk_pix);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'h0200;
    rd_hold  = ref_mem[14'h0200];
    cpu_q.push_back(exp_t'{cyc + 3, rd_hold});
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_pix);
      n_cmp++;
      if (cpu_nwait !== (j == 2)) begin
        n_err++;
        $display("FAIL postreset_nwait slot %0d: got %b, required %b", j, cpu_nwait, (j == 2));
      end
    end
    cpu_req = 1'b0;
  endtask

`ifdef VRAM_ARB_WAITCNT_EN
  task automatic test_waitcnt();
    @(negedge clk_pix);
    vid_req  = 1'b1;
    vid_addr = 13'h0000;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'h1801;
    vid_q.push_back(exp_t'{cyc + 3, ref_mem[14'h0000]});
    rd_hold = ref_mem[14'h1801];
    cpu_q.push_back(exp_t'{cyc + 4, rd_hold});
    @(negedge clk_pix);
    vid_req = 1'b0;
    repeat (3) @(negedge clk_pix);
    cpu_req = 1'b0;
    @(negedge clk_pix);
    cpu_req  = 1'b1;
    cpu_addr = 14'h1802;
    rd_hold  = ref_mem[14'h1802];
    cpu_q.push_back(exp_t'{cyc + 3, rd_hold});
    repeat (3) @(negedge clk_pix);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk_pix);
    n_cmp++;
    if (cpu_wait_cycles !== 16'd5) begin
      n_err++;
      $display("FAIL waitcnt_five: got %0d, required 5", cpu_wait_cycles);
    end
    force dut.cpu_nwait = 1'b0;
    repeat (70000) @(negedge clk_pix);
    release dut.cpu_nwait;
    n_cmp++;
    if (cpu_wait_cycles !== 16'hFFFF) begin
      n_err++;
      $display("FAIL waitcnt_saturate: got %h, required FFFF", cpu_wait_cycles);
    end
    repeat (2) @(negedge clk_pix);
  endtask
`endif

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] <= pat(i);
      ref_mem[i] = pat(i);
    end
    test_reset();
    test_video_read();
    test_cpu_rw();
    test_collision();
    test_video_cpu_pressure();
    test_reset_mid_access();
`ifdef VRAM_ARB_WAITCNT_EN
    test_waitcnt();
`endif
    repeat (5) @(negedge clk_pix);
    n_cmp++;
    if (vid_q.size() != 0 || cpu_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d video and %0d cpu results outstanding, required 0/0", vid_q.size(), cpu_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
